uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_sync_fifo.sv | 59 +++++
 rtl/uart_tx_fifo.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, minimum character length
// and the parity helper used by the TX (and later the RX).
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP1    = 3'd4,
        S_STOP2    = 3'd5,
        S_BREAK    = 3'd6,
        S_BRK_STOP = 3'd7
    } tx_state_t;

    localparam int UART_MIN_DATA_BITS = 5;
    localparam int UART_PAR_W         = 16;

    // Parity over the low `len` bits only; odd parity is the complement of the XOR.
    function automatic logic calc_parity(input logic [UART_PAR_W-1:0] data,
                                         input logic [3:0]            len,
                                         input logic                  odd);
        logic p;
        p = odd;
        for (int i = 0; i < UART_PAR_W; i++) begin
            if (i < int'(len)) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy count.
// Shared between the UART transmitter and receiver.
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly AW bits wide, so DEPTH being a power of two gives the wrap for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, run-time configurable framing, CTS gating
// and BREAK generation, stepping one bit per baud tick.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | line high, waiting for a tick with data+CTS or a break
// S_START    | start bit (0)
// S_DATA     | data bits, LSB first, from the shadow shift register
// S_PARITY   | latched parity bit
// S_STOP1    | first stop bit (1)
// S_STOP2    | second stop bit (1), only when two stops were latched
// S_BREAK    | line held low while brk_req stays high
// S_BRK_STOP | one high bit period closing a break
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 16,
    parameter int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     in_valid,
    input  logic [MAX_DATA_BITS-1:0] in_data,
    output logic                     in_ready,
    input  logic [3:0]               cfg_data_bits,
    input  logic                     cfg_parity_en,
    input  logic                     cfg_parity_odd,
    input  logic                     cfg_stop2,
    input  logic                     cts,
    input  logic                     brk_req,
    output logic                     tx_out,
    output logic                     tx_busy,
    output logic                     tx_done,
    output logic [CNT_W-1:0]         fifo_count,
    output logic                     fifo_empty
);

    tx_state_t                state;
    logic [MAX_DATA_BITS-1:0] shift;
    logic [3:0]               bit_idx;
    logic [3:0]               sh_len;
    logic                     sh_par_en;
    logic                     sh_parity;
    logic                     sh_stop2;

    logic                     fifo_full;
    logic [MAX_DATA_BITS-1:0] head;
    logic [3:0]               cfg_len;
    logic                     at_boundary;
    logic                     start_ok;

    assign in_ready = !fifo_full;

    uart_sync_fifo #(
        .WIDTH (MAX_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid && in_ready),
        .wr_data (in_data),
        .pop     (start_ok),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        cfg_len = cfg_data_bits;
        if (cfg_data_bits < 4'(UART_MIN_DATA_BITS) || cfg_data_bits > 4'(MAX_DATA_BITS)) begin
            cfg_len = 4'(MAX_DATA_BITS);
        end
    end

    // The tick that ends the last stop bit (or the break stop) also decides what
    // comes next, so back-to-back characters leave no idle bit between them.
    assign at_boundary = (state == S_IDLE)
                      || (state == S_STOP1 && !sh_stop2)
                      || (state == S_STOP2)
                      || (state == S_BRK_STOP);

    assign start_ok = tick && at_boundary && !brk_req && cts && !fifo_empty;

    always_ff @(posedge clk) begin
        tx_done <= 1'b0;
        if (rst) begin
            state     <= S_IDLE;
            tx_out    <= 1'b1;
            tx_busy   <= 1'b0;
            shift     <= '0;
            bit_idx   <= '0;
            sh_len    <= 4'(MAX_DATA_BITS);
            sh_par_en <= 1'b0;
            sh_parity <= 1'b0;
            sh_stop2  <= 1'b0;
        end else if (tick) begin
            if (at_boundary) begin
                tx_done <= (state == S_STOP1) || (state == S_STOP2);
                if (brk_req) begin
                    state   <= S_BREAK;
                    tx_out  <= 1'b0;
                    tx_busy <= 1'b1;
                end else if (start_ok) begin
                    state     <= S_START;
                    tx_out    <= 1'b0;
                    tx_busy   <= 1'b1;
                    shift     <= head;
                    sh_len    <= cfg_len;
                    sh_par_en <= cfg_parity_en;
                    sh_parity <= calc_parity(UART_PAR_W'(head), cfg_len, cfg_parity_odd);
                    sh_stop2  <= cfg_stop2;
                end else begin
                    state   <= S_IDLE;
                    tx_out  <= 1'b1;
                    tx_busy <= 1'b0;
                end
            end else begin
                case (state)
                    S_START: begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                        tx_out  <= shift[0];
                        shift   <= shift >> 1;
                    end
                    S_DATA: begin
                        if (bit_idx == 4'(sh_len - 4'd1)) begin
                            if (sh_par_en) begin
                                state  <= S_PARITY;
                                tx_out <= sh_parity;
                            end else begin
                                state  <= S_STOP1;
                                tx_out <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            tx_out  <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
                    S_PARITY: begin
                        state  <= S_STOP1;
                        tx_out <= 1'b1;
                    end
                    S_STOP1: begin
                        state  <= S_STOP2;
                        tx_out <= 1'b1;
                    end
                    S_BREAK: begin
                        if (!brk_req) begin
                            state  <= S_BRK_STOP;
                            tx_out <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        tx_out  <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frames expected from the framing rules are queued at push
// time and a line monitor decodes tx_out tick by tick and compares.
module tb_uart_tx_fifo;

    localparam int MDB = 9;
    localparam int CW  = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           tick = 1'b0;
    logic           in_valid = 1'b0;
    logic [MDB-1:0] in_data = '0;
    logic           in_ready;
    logic [3:0]     cfg_data_bits = 4'd8;
    logic           cfg_parity_en = 1'b0;
    logic           cfg_parity_odd = 1'b0;
    logic           cfg_stop2 = 1'b0;
    logic           cts = 1'b1;
    logic           brk_req = 1'b0;
    logic           tx_out;
    logic           tx_busy;
    logic           tx_done;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;

    uart_tx_fifo #(.MAX_DATA_BITS(MDB), .FIFO_DEPTH(16), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .tick           (tick),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .cts            (cts),
        .brk_req        (brk_req),
        .tx_out         (tx_out),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done),
        .fifo_count     (fifo_count),
        .fifo_empty     (fifo_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        bit          is_break;
        bit          no_gap;
    } frame_t;

    frame_t      exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          tp = 16;
    int          done_cnt = 0;
    int          exp_done = 0;
    bit          in_frame = 0;
    frame_t      cur;
    int          bit_pos = 0;
    int          gap = 0;
    int          brk_zeros = 0;
    logic [15:0] rx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Tick is raised 1 time unit after a posedge and consumed at the following posedge.
    initial begin
        forever begin
            repeat (tp - 1) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line monitor: during a tick cycle tx_out holds the bit of the period now ending.
    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (rst) begin
            in_frame = 0;
            gap = 0;
        end else if (tick) begin
            if (!in_frame) begin
                if (tx_out == 1'b0) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_start: got start bit, expected idle line");
                    end else begin
                        cur = exp_q.pop_front();
                        in_frame = 1;
                        if (cur.no_gap) check("idle_gap", gap, 0);
                        rx = '0;
                        bit_pos = 1;
                        brk_zeros = 1;
                    end
                end else begin
                    gap++;
                end
            end else if (cur.is_break) begin
                if (tx_out == 1'b0) begin
                    brk_zeros++;
                end else begin
                    check("break_long_enough", brk_zeros >= 3, 1);
                    in_frame = 0;
                    gap = 0;
                end
            end else begin
                rx[bit_pos] = tx_out;
                bit_pos++;
                if (bit_pos == cur.nbits) begin
                    check("frame_bits", rx, cur.bits);
                    in_frame = 0;
                    gap = 0;
                end
            end
        end
    end

    function automatic frame_t make_frame(input logic [MDB-1:0] d, input bit no_gap);
        frame_t f;
        int len, n, dv;
        len = (cfg_data_bits < 5 || cfg_data_bits > 9) ? 9 : int'(cfg_data_bits);
        dv = int'(d) & ((1 << len) - 1);
        f.bits = '0;
        f.is_break = 0;
        f.no_gap = no_gap;
        n = 1;
        for (int i = 0; i < len; i++) begin
            f.bits[n] = dv[i];
            n++;
        end
        if (cfg_parity_en) begin
            f.bits[n] = (($countones(dv) % 2) == 1) ^ cfg_parity_odd;
            n++;
        end
        f.bits[n] = 1'b1;
        n++;
        if (cfg_stop2) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.nbits = n;
        return f;
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic push(input logic [MDB-1:0] d, input bit no_gap);
        int b = 0;
        while (!in_ready && b < 5000) begin
            @(negedge clk);
            b++;
        end
        check("push_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_data = d;
        exp_q.push_back(make_frame(d, no_gap));
        exp_done++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while ((exp_q.size() != 0 || in_frame || tx_busy || !fifo_empty) && b < 30000) begin
            @(negedge clk);
            b++;
        end
        check("drain_in_time", b < 30000, 1);
        repeat (2) @(negedge clk);
        check("done_count", done_cnt, exp_done);
    endtask

    task automatic wait_done(input int target, input string name);
        int b = 0;
        while (done_cnt < target && b < 20000) begin
            @(negedge clk);
            b++;
        end
        check(name, done_cnt >= target, 1);
    endtask

    task automatic set_cfg(input logic [3:0] db, input logic pe, input logic po, input logic s2);
        cfg_data_bits = db;
        cfg_parity_en = pe;
        cfg_parity_odd = po;
        cfg_stop2 = s2;
    endtask

    initial begin
        int b, base, n;
        frame_t brk;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_out", tx_out, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_fifo_empty", fifo_empty, 1);
        rst = 1'b0;
        @(negedge clk);

        // 8N1 0x55 with a 16-clock bit period
        set_cfg(4'd8, 0, 0, 0);
        push(9'h055, 0);
        b = 0;
        while (!tx_done && b < 5000) begin
            @(negedge clk);
            b++;
        end
        check("t1_done_seen", tx_done, 1);
        check("t1_busy_falls_with_done", tx_busy, 0);
        drain();
        tp = 4;

        // 7E2 and 5O1
        set_cfg(4'd7, 1, 0, 1);
        push(9'h041, 0);
        drain();
        set_cfg(4'd5, 1, 1, 0);
        push(9'h01F, 0);
        drain();

        // config change mid-character must not affect the character in flight
        set_cfg(4'd8, 0, 0, 0);
        push(9'h0A5, 0);
        b = 0;
        while (!tx_busy && b < 1000) begin
            @(negedge clk);
            b++;
        end
        set_cfg(4'd5, 1, 0, 1);
        drain();
        set_cfg(4'd8, 0, 0, 0);

        // fill the FIFO with CTS low, then release: back-to-back frames
        cts = 1'b0;
        for (int i = 0; i < 16; i++) push(9'(i), i != 0);
        check("t3_count_full", fifo_count, 16);
        check("t3_in_ready_full", in_ready, 0);
        cts = 1'b1;
        drain();
        check("t3_fifo_empty", fifo_empty, 1);

        // CTS drops during character 2 of 3
        base = done_cnt;
        push(9'h011, 0);
        push(9'h022, 1);
        push(9'h033, 0);
        wait_done(base + 1, "t4_char1_done");
        repeat (2) @(negedge clk);
        cts = 1'b0;
        wait_done(base + 2, "t4_char2_done");
        repeat (5 * tp) @(negedge clk);
        check("t4_idle_line", tx_out, 1);
        check("t4_idle_busy", tx_busy, 0);
        check("t4_held_count", fifo_count, 1);
        cts = 1'b1;
        b = 0;
        while (!tick && b < 100) begin
            @(negedge clk);
            b++;
        end
        @(negedge clk);
        check("t4_start_busy", tx_busy, 1);
        check("t4_start_bit", tx_out, 0);
        drain();

        // break requested mid-character
        base = done_cnt;
        push(9'h05A, 0);
        b = 0;
        while (!tx_busy && b < 1000) begin
            @(negedge clk);
            b++;
        end
        brk_req = 1'b1;
        brk.bits = '0;
        brk.nbits = 0;
        brk.is_break = 1;
        brk.no_gap = 1;
        exp_q.push_back(brk);
        push(9'h0C3, 1);
        wait_done(base + 1, "t5_char_before_break");
        repeat (6 * tp) @(negedge clk);
        check("t5_break_low", tx_out, 0);
        brk_req = 1'b0;
        drain();

        // reset while a character is in S_DATA with four queued behind it
        push(9'h001, 0);
        push(9'h002, 0);
        push(9'h003, 0);
        push(9'h004, 0);
        push(9'h005, 0);
        repeat (3 * tp) @(negedge clk);
        check("t6_count_before", fifo_count, 4);
        check("t6_busy_before", tx_busy, 1);
        base = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_tx_out", tx_out, 1);
        check("t6_rst_busy", tx_busy, 0);
        check("t6_rst_count", fifo_count, 0);
        check("t6_rst_empty", fifo_empty, 1);
        check("t6_rst_done", tx_done, 0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        exp_done -= 5;
        rst = 1'b0;
        repeat (4 * tp) @(negedge clk);
        check("t6_no_done", done_cnt, base);
        check("t6_line_idle", tx_out, 1);

        // randomized framing and data
        for (int r = 0; r < 15; r++) begin
            if ($urandom_range(0, 3) == 0) cfg_data_bits = 4'($urandom_range(0, 15));
            else cfg_data_bits = 4'($urandom_range(5, 9));
            cfg_parity_en = 1'($urandom_range(0, 1));
            cfg_parity_odd = 1'($urandom_range(0, 1));
            cfg_stop2 = 1'($urandom_range(0, 1));
            tp = $urandom_range(2, 6);
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                push(9'($urandom_range(0, 511)), 0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
